// File: rtl/matmul_bias_act_if.sv
// matmul_bias_act_if: row stream from the matmul core into the bias/activation
// stage, and the framed, handshaked row stream out of it.
interface matmul_bias_act_if #(
    parameter int WIDTH = 16,
    parameter int COLS  = 6
);
    logic                  in_valid;
    logic [WIDTH*COLS-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH*COLS-1:0] out_data;
    logic                  out_last;
    logic                  out_done;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, out_done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, out_done
    );
endinterface

// File: rtl/matmul_bias_act.sv
// matmul_bias_act: per-column bias add, saturation and optional ReLU on matmul
// result rows, buffered in a first-word-fall-through FIFO with matrix framing.
module matmul_bias_act #(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int COLS       = 6,
    parameter int ROWS       = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  bias_valid,
    input  logic [WIDTH*COLS-1:0] bias_in,
    input  logic                  relu_en,
    output logic                  overflow,
    matmul_bias_act_if.slave      bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(ROWS);
    localparam int SW = WIDTH + 1;
    localparam logic [0:0] STREAM = 1'b0;
    localparam logic [0:0] DONE   = 1'b1;

    logic [WIDTH*COLS-1:0] bias, s2_data, res_n;
    logic [SW*COLS-1:0]    s1_sum, sum_n;
    logic                  s1_valid, s1_relu, s2_valid;
    logic [WIDTH*COLS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr, rd;
    logic [CW-1:0]         cnt;
    logic [0:0]            state;
    logic                  valid, full, pop, push, wrap;

    if (FRAC_WIDTH >= WIDTH || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ROWS < 2) begin : g_bad_params
        $error("matmul_bias_act: unsupported parameter set");
    end

    genvar j;
    for (j = 0; j < COLS; j++) begin : g_col
        logic [WIDTH-1:0] x, b, sat;
        logic [SW-1:0]    s;
        assign x = bus.in_data[j*WIDTH +: WIDTH];
        assign b = bias[j*WIDTH +: WIDTH];
        assign sum_n[j*SW +: SW] = {x[WIDTH-1], x} + {b[WIDTH-1], b};
        assign s = s1_sum[j*SW +: SW];
        // Top two bits disagree only when the sum left the WIDTH-bit range.
        assign sat = (s[WIDTH] != s[WIDTH-1]) ? {s[WIDTH], {(WIDTH-1){~s[WIDTH]}}} : s[WIDTH-1:0];
        assign res_n[j*WIDTH +: WIDTH] = (s1_relu & sat[WIDTH-1]) ? '0 : sat;
    end

    assign valid = wr != rd;
    assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign pop   = valid & bus.out_ready;
    assign push  = s2_valid & (~full | pop);
    assign wrap  = cnt == CW'(ROWS - 1);

    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? mem[rd[AW-1:0]] : '0;
    assign bus.out_last  = valid & wrap;
    assign bus.out_done  = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias     <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_relu  <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            wr       <= '0;
            rd       <= '0;
            cnt      <= '0;
            state    <= STREAM;
            overflow <= 1'b0;
        end else begin
            if (bias_valid) bias <= bias_in;
            s1_valid <= en & bus.in_valid;
            if (en & bus.in_valid) begin
                s1_sum  <= sum_n;
                s1_relu <= relu_en;
            end
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= res_n;
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            if (s2_valid & full & ~pop) overflow <= 1'b1;
            if (pop) cnt <= wrap ? '0 : cnt + 1'b1;
            state <= (pop & wrap) ? DONE : STREAM;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr[AW-1:0]] <= s2_data;
    end
endmodule

// File: tb/tb_matmul_bias_act.sv
// tb_matmul_bias_act: directed and randomized rows checked against a queue-based
// reference of bias, saturation, ReLU, FIFO capacity and matrix framing.
module tb_matmul_bias_act;
    localparam int W = 16, C = 6, R = 12, DEP = 4, D = W * C;

    logic         clk = 1'b0, rst_n = 1'b0, en = 1'b0, bias_valid = 1'b0, relu_en = 1'b0;
    logic [D-1:0] bias_in = '0;
    logic         overflow;

    matmul_bias_act_if #(.WIDTH(W), .COLS(C)) bus ();

    matmul_bias_act #(.WIDTH(W), .FRAC_WIDTH(8), .COLS(C), .ROWS(R), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bias_valid(bias_valid), .bias_in(bias_in),
        .relu_en(relu_en), .overflow(overflow), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [D-1:0] d;
        int           t;
    } ent_t;

    ent_t         q[$];
    int           cy, rc, n_assert, n_fail, n_pop, n_last, sent;
    logic [D-1:0] bias_m;
    logic         done_exp, ovf_exp;

    function automatic logic [D-1:0] ref_row(input logic [D-1:0] x, input logic [D-1:0] b, input logic r);
        int s;
        for (int k = 0; k < C; k++) begin
            s = int'($signed(x[k*W +: W])) + int'($signed(b[k*W +: W]));
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            if (r && s < 0) s = 0;
            ref_row[k*W +: W] = 16'(s);
        end
    endfunction

    function automatic logic [D-1:0] rnd();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model, cross the rising edge.
    task automatic cyc();
        logic vis, pop;
        int   nv;
        ent_t e;
        vis = q.size() > 0 && q[0].t + 2 <= cy;
        chk("out_valid", bus.out_valid, vis);
        chk("out_done", bus.out_done, done_exp);
        chk("overflow", overflow, ovf_exp);
        if (vis) begin
            chk("out_data", bus.out_data, q[0].d);
            chk("out_last", bus.out_last, rc == R - 1);
        end
        pop = vis && bus.out_ready;
        done_exp = pop && rc == R - 1;
        if (pop) begin
            n_pop++;
            if (bus.out_last) n_last++;
            void'(q.pop_front());
            rc = (rc == R - 1) ? 0 : rc + 1;
        end
        nv = 0;
        foreach (q[i]) if (q[i].t + 2 <= cy) nv++;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].t + 2 == cy + 1) begin
                if (nv >= DEP) begin
                    q.delete(i);
                    ovf_exp = 1'b1;
                end
                break;
            end
        end
        if (en && bus.in_valid) begin
            e.d = ref_row(bus.in_data, bias_m, relu_en);
            e.t = cy + 1;
            q.push_back(e);
        end
        if (bias_valid) bias_m = bias_in;
        @(posedge clk);
        cy++;
        @(negedge clk);
    endtask

    task automatic send(input logic [D-1:0] d, input logic r);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        relu_en      = r;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && q.size() > 0; k++) cyc();
        chk("drain timeout", q.size() == 0, 1'b1);
        idle(2);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst out_valid", bus.out_valid, 1'b0);
        chk("rst out_data", bus.out_data, '0);
        chk("rst out_last", bus.out_last, 1'b0);
        chk("rst out_done", bus.out_done, 1'b0);
        chk("rst overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        rc = 0;
        done_exp = 1'b0;
        ovf_exp = 1'b0;
        bias_m = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [D-1:0] d;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        en = 1'b1;
        bias_m = '0;
        done_exp = 1'b0;
        ovf_exp = 1'b0;
        #1;
        chk("init out_valid", bus.out_valid, 1'b0);
        chk("init out_data", bus.out_data, '0);
        chk("init out_done", bus.out_done, 1'b0);
        chk("init overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bias load and two-edge latency
        bias_in = {C{16'h0100}};
        bias_valid = 1'b1;
        cyc();
        bias_valid = 1'b0;
        send({C{16'h0100}}, 1'b0);
        idle(2);
        chk("bias row valid", bus.out_valid, 1'b1);
        chk("bias row data", bus.out_data, {C{16'h0200}});
        drain();

        // Row sampled with bias_valid uses the old bias; then saturation both ways
        d = rnd();
        d[15:0] = 16'h0200;
        d[31:16] = 16'hFE00;
        bias_in = d;
        bias_valid = 1'b1;
        send(rnd(), 1'b0);
        bias_valid = 1'b0;
        d = rnd();
        d[15:0] = 16'h7F00;
        d[31:16] = 16'h8100;
        send(d, 1'b0);
        idle(2);
        chk("sat pos", bus.out_data[15:0], 16'h7FFF);
        chk("sat neg", bus.out_data[31:16], 16'h8000);
        drain();

        // ReLU toggled on back-to-back rows
        bus.out_ready = 1'b0;
        bias_in = {C{16'h0080}};
        bias_valid = 1'b1;
        cyc();
        bias_valid = 1'b0;
        send({C{16'hFF00}}, 1'b1);
        send({C{16'hFF00}}, 1'b0);
        send({C{16'hFF00}}, 1'b1);
        send({C{16'hFF00}}, 1'b0);
        idle(2);
        chk("relu on", bus.out_data, '0);
        bus.out_ready = 1'b1;
        cyc();
        chk("relu off", bus.out_data, {C{16'hFF80}});
        drain();

        // en low masks in_valid
        en = 1'b0;
        send(rnd(), 1'b0);
        en = 1'b1;
        idle(4);

        // Overflow with stalled output
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) send(rnd(), k[0]);
        idle(3);
        chk("overflow sticky", overflow, 1'b1);
        n_pop = 0;
        n_last = 0;
        bus.out_ready = 1'b1;
        drain();
        chk("overflow kept rows", n_pop, 4);
        chk("overflow no last", n_last, 0);

        // Framing, continuous ready
        do_reset();
        bias_in = rnd();
        bias_valid = 1'b1;
        cyc();
        bias_valid = 1'b0;
        n_pop = 0;
        n_last = 0;
        for (int k = 0; k < 24; k++) send(rnd(), 1'($urandom_range(0, 1)));
        drain();
        chk("frame pops", n_pop, 24);
        chk("frame lasts", n_last, 2);

        // Framing, random ready, issue throttled so nothing can drop
        n_pop = 0;
        n_last = 0;
        sent = 0;
        for (int k = 0; k < 2000 && sent < 24; k++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (q.size() < DEP && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data = rnd();
                relu_en = 1'($urandom_range(0, 1));
                sent++;
            end else bus.in_valid = 1'b0;
            cyc();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("rand pops", n_pop, 24);
        chk("rand lasts", n_last, 2);
        chk("rand no overflow", overflow, 1'b0);

        // Reset mid-matrix with rows buffered
        for (int k = 0; k < 3; k++) send(rnd(), 1'b0);
        drain();
        bus.out_ready = 1'b0;
        send(rnd(), 1'b0);
        send(rnd(), 1'b0);
        idle(3);
        chk("pre-reset buffered", bus.out_valid, 1'b1);
        do_reset();
        bus.out_ready = 1'b1;
        n_pop = 0;
        n_last = 0;
        for (int k = 0; k < 12; k++) send(rnd(), 1'b0);
        drain();
        chk("post-reset pops", n_pop, 12);
        chk("post-reset lasts", n_last, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
